// File: rtl/aes_xts_data_out_buf.sv
// ---------------------------------------------------------------------------
// aes_xts_data_out_buf
//
// Output-side block buffer of the AES-XTS-256 datapath. Encrypted blocks from
// the cipher core are delayed by one block so that the output half of
// ciphertext stealing can be done here. When the final plaintext block was
// partial, the freshly encrypted final block is sent first as a full block,
// and the held block (the stolen one) follows truncated to the partial size.
// The held block is also exported so the input side can steal its tail bits.
//
// Ports:
//   inClk, inRst          clock, synchronous active-high reset
//   inCoreWr/inCoreData   block from the core, accepted when outCoreReady=1
//   inLastBlock           core block is the final block of the data unit
//   inSizeLastData        valid bits of final plaintext block (0/>=128 full)
//   outCoreReady          buffer can take a core block this cycle
//   outData/outValid      registered output block and its valid flag
//   inOutReady            consumer accepts outData this cycle
//   outLast               outData is the last block of the data unit
//   outSizeLastData       valid bits in outData (128 or partial size)
//   outStealData          currently held block, straight from the register
//   outError              sticky protocol error, cleared only by reset
// ---------------------------------------------------------------------------
module aes_xts_data_out_buf (
    input  logic         inClk,
    input  logic         inRst,
    input  logic         inCoreWr,
    input  logic [127:0] inCoreData,
    input  logic         inLastBlock,
    input  logic [7:0]   inSizeLastData,
    output logic         outCoreReady,
    output logic [127:0] outData,
    output logic         outValid,
    input  logic         inOutReady,
    output logic         outLast,
    output logic [7:0]   outSizeLastData,
    output logic [127:0] outStealData,
    output logic         outError
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [127:0]   reg_held, reg_held_next;
    logic [7:0]     reg_size, reg_size_next;
    logic [127:0]   out_data, out_data_next;
    logic           out_valid, out_valid_next;
    logic           out_last, out_last_next;
    logic [7:0]     out_size, out_size_next;
    logic           err, err_next;

    logic           out_free;
    logic           core_ready;
    logic           accept;
    logic           is_partial;
    logic [127:0]   tail_mask;

    assign out_free   = !out_valid || inOutReady;
    assign core_ready = (state != TAIL) && out_free;
    assign accept     = inCoreWr && core_ready;
    assign is_partial = (inSizeLastData != 8'd0) && (inSizeLastData < 8'd128);

    // Keep only the low reg_size bits of the stolen block; a stored size of
    // 128 means the final block was full and nothing is masked.
    always_comb begin
        tail_mask = '0;
        for (int i = 0; i < 128; i++) begin
            tail_mask[i] = (i < int'(reg_size));
        end
    end

    // Next-state and next-register logic. A load always wins over a consume,
    // which is what gives zero-bubble streaming with inOutReady held high.
    always_comb begin
        state_next    = state;
        reg_held_next = reg_held;
        reg_size_next = reg_size;
        out_data_next = out_data;
        out_valid_next = out_valid;
        out_last_next = out_last;
        out_size_next = out_size;
        err_next      = err;

        if (out_valid && inOutReady) begin
            out_valid_next = 1'b0;
        end

        case (state)
            EMPTY: begin
                if (accept) begin
                    if (!inLastBlock) begin
                        reg_held_next = inCoreData;
                        state_next    = HOLD;
                    end else if (!is_partial) begin
                        out_data_next  = inCoreData;
                        out_valid_next = 1'b1;
                        out_last_next  = 1'b1;
                        out_size_next  = 8'd128;
                    end else begin
                        // Nothing held to steal from: drop the block and flag it.
                        err_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    out_valid_next = 1'b1;
                    out_last_next  = 1'b0;
                    out_size_next  = 8'd128;
                    if (inLastBlock && is_partial) begin
                        // The held block stays put: it becomes the stolen tail.
                        out_data_next = inCoreData;
                        reg_size_next = inSizeLastData;
                        state_next    = TAIL;
                    end else begin
                        out_data_next = reg_held;
                        reg_held_next = inCoreData;
                        if (inLastBlock) begin
                            reg_size_next = 8'd128;
                            state_next    = TAIL;
                        end
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    out_data_next  = reg_held & tail_mask;
                    out_valid_next = 1'b1;
                    out_last_next  = 1'b1;
                    out_size_next  = reg_size;
                    state_next     = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state     <= EMPTY;
            reg_held  <= '0;
            reg_size  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_size  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            reg_held  <= reg_held_next;
            reg_size  <= reg_size_next;
            out_data  <= out_data_next;
            out_valid <= out_valid_next;
            out_last  <= out_last_next;
            out_size  <= out_size_next;
            err       <= err_next;
        end
    end

    assign outCoreReady    = core_ready;
    assign outData         = out_data;
    assign outValid        = out_valid;
    assign outLast         = out_last;
    assign outSizeLastData = out_size;
    assign outStealData    = reg_held;
    assign outError        = err;

endmodule

// File: tb/tb_aes_xts_data_out_buf.sv
// ---------------------------------------------------------------------------
// tb_aes_xts_data_out_buf
//
// Directed self-checking bench for aes_xts_data_out_buf: full-block streams,
// ciphertext stealing with a 40-bit tail, single-block messages, the partial
// block error, a backpressured stream and a reset while the tail is pending.
// ---------------------------------------------------------------------------
module tb_aes_xts_data_out_buf;

    logic         inClk;
    logic         inRst;
    logic         inCoreWr;
    logic [127:0] inCoreData;
    logic         inLastBlock;
    logic [7:0]   inSizeLastData;
    logic         outCoreReady;
    logic [127:0] outData;
    logic         outValid;
    logic         inOutReady;
    logic         outLast;
    logic [7:0]   outSizeLastData;
    logic [127:0] outStealData;
    logic         outError;

    int compared   = 0;
    int mismatched = 0;

    aes_xts_data_out_buf dut (
        .inClk           (inClk),
        .inRst           (inRst),
        .inCoreWr        (inCoreWr),
        .inCoreData      (inCoreData),
        .inLastBlock     (inLastBlock),
        .inSizeLastData  (inSizeLastData),
        .outCoreReady    (outCoreReady),
        .outData         (outData),
        .outValid        (outValid),
        .inOutReady      (inOutReady),
        .outLast         (outLast),
        .outSizeLastData (outSizeLastData),
        .outStealData    (outStealData),
        .outError        (outError)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic wr, input logic [127:0] data, input logic last, input logic [7:0] size);
        inCoreWr       = wr;
        inCoreData     = data;
        inLastBlock    = last;
        inSizeLastData = size;
    endtask

    localparam logic [127:0] BLK_A  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] BLK_B  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] BLK_C  = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    localparam logic [127:0] BLK_CC = 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCC;
    localparam logic [127:0] BLK_PP = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    localparam logic [127:0] CC_40  = 128'h00000000_00000000_000000CC_CCCCCCCC;
    localparam logic [127:0] BLK_X  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] BLK_Y  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    logic [127:0] stream_blk [4];
    int tx;
    int rx;
    int cyc;
    logic accepted;

    initial begin
        stream_blk[0] = 128'h10000000_00000000_00000000_00000001;
        stream_blk[1] = 128'h20000000_00000000_00000000_00000002;
        stream_blk[2] = 128'h30000000_00000000_00000000_00000003;
        stream_blk[3] = 128'h40000000_00000000_00000000_00000004;

        inRst      = 1'b1;
        inOutReady = 1'b1;
        drive(1'b0, '0, 1'b0, 8'd0);
        tick();
        tick();
        inRst = 1'b0;
        #1;
        check("rst_valid", {127'd0, outValid}, 128'd0);
        check("rst_data", outData, 128'd0);
        check("rst_last", {127'd0, outLast}, 128'd0);
        check("rst_size", {120'd0, outSizeLastData}, 128'd0);
        check("rst_steal", outStealData, 128'd0);
        check("rst_error", {127'd0, outError}, 128'd0);
        check("rst_ready", {127'd0, outCoreReady}, 128'd1);

        // Three full blocks, C last.
        drive(1'b1, BLK_A, 1'b0, 8'd0);
        tick();
        check("s3_hold_valid", {127'd0, outValid}, 128'd0);
        check("s3_steal_a", outStealData, BLK_A);
        drive(1'b1, BLK_B, 1'b0, 8'd0);
        tick();
        check("s3_out_a", outData, BLK_A);
        check("s3_a_valid", {127'd0, outValid}, 128'd1);
        check("s3_a_last", {127'd0, outLast}, 128'd0);
        check("s3_a_size", {120'd0, outSizeLastData}, 128'd128);
        drive(1'b1, BLK_C, 1'b1, 8'd0);
        tick();
        check("s3_out_b", outData, BLK_B);
        check("s3_b_last", {127'd0, outLast}, 128'd0);
        check("s3_tail_ready", {127'd0, outCoreReady}, 128'd0);
        drive(1'b0, '0, 1'b0, 8'd0);
        tick();
        check("s3_out_c", outData, BLK_C);
        check("s3_c_valid", {127'd0, outValid}, 128'd1);
        check("s3_c_last", {127'd0, outLast}, 128'd1);
        check("s3_c_size", {120'd0, outSizeLastData}, 128'd128);
        tick();
        check("s3_drained", {127'd0, outValid}, 128'd0);
        check("s3_ready_again", {127'd0, outCoreReady}, 128'd1);

        // Ciphertext stealing with a 40-bit final block.
        drive(1'b1, BLK_A, 1'b0, 8'd0);
        tick();
        drive(1'b1, BLK_CC, 1'b0, 8'd0);
        tick();
        check("cs_out_a", outData, BLK_A);
        drive(1'b1, BLK_PP, 1'b1, 8'd40);
        tick();
        check("cs_out_pp", outData, BLK_PP);
        check("cs_pp_last", {127'd0, outLast}, 128'd0);
        check("cs_pp_size", {120'd0, outSizeLastData}, 128'd128);
        check("cs_steal_cc", outStealData, BLK_CC);
        drive(1'b0, '0, 1'b0, 8'd0);
        tick();
        check("cs_out_tail", outData, CC_40);
        check("cs_tail_last", {127'd0, outLast}, 128'd1);
        check("cs_tail_size", {120'd0, outSizeLastData}, 128'd40);
        tick();
        check("cs_drained", {127'd0, outValid}, 128'd0);

        // Single full block from EMPTY.
        drive(1'b1, BLK_X, 1'b1, 8'd0);
        tick();
        drive(1'b0, '0, 1'b0, 8'd0);
        check("one_out_x", outData, BLK_X);
        check("one_last", {127'd0, outLast}, 128'd1);
        check("one_size", {120'd0, outSizeLastData}, 128'd128);
        check("one_empty_ready", {127'd0, outCoreReady}, 128'd1);
        tick();
        check("one_drained", {127'd0, outValid}, 128'd0);

        // Partial final block with nothing held.
        drive(1'b1, BLK_X, 1'b1, 8'd8);
        tick();
        drive(1'b0, '0, 1'b0, 8'd0);
        check("err_set", {127'd0, outError}, 128'd1);
        check("err_no_valid", {127'd0, outValid}, 128'd0);
        tick();
        check("err_sticky", {127'd0, outError}, 128'd1);
        inRst = 1'b1;
        tick();
        inRst = 1'b0;
        check("err_cleared", {127'd0, outError}, 128'd0);

        // Backpressured stream, consumer ready on alternate cycles.
        tx  = 0;
        rx  = 0;
        cyc = 0;
        while (rx < 4 && cyc < 40) begin
            inOutReady = (cyc % 2 == 0);
            drive(tx < 4, (tx < 4) ? stream_blk[tx] : 128'd0, tx == 3, 8'd0);
            #1;
            if (outValid && !inOutReady) begin
                check("bp_ready_low", {127'd0, outCoreReady}, 128'd0);
            end
            accepted = inCoreWr && outCoreReady;
            if (outValid && inOutReady) begin
                check("bp_data", outData, stream_blk[rx]);
                check("bp_last", {127'd0, outLast}, {127'd0, rx == 3});
                rx++;
            end
            tick();
            if (accepted) tx++;
            cyc++;
        end
        check("bp_all_received", 128'(rx), 128'd4);
        drive(1'b0, '0, 1'b0, 8'd0);
        inOutReady = 1'b1;
        tick();
        check("bp_no_extra", {127'd0, outValid}, 128'd0);

        // Reset while the stolen tail is pending.
        inOutReady = 1'b0;
        drive(1'b1, BLK_A, 1'b0, 8'd0);
        tick();
        drive(1'b1, BLK_B, 1'b1, 8'd16);
        tick();
        drive(1'b0, '0, 1'b0, 8'd0);
        check("tr_pending_valid", {127'd0, outValid}, 128'd1);
        check("tr_pending_ready", {127'd0, outCoreReady}, 128'd0);
        inRst = 1'b1;
        tick();
        inRst      = 1'b0;
        inOutReady = 1'b1;
        #1;
        check("tr_valid", {127'd0, outValid}, 128'd0);
        check("tr_steal", outStealData, 128'd0);
        check("tr_ready", {127'd0, outCoreReady}, 128'd1);
        drive(1'b1, BLK_Y, 1'b1, 8'd0);
        tick();
        drive(1'b0, '0, 1'b0, 8'd0);
        check("tr_empty_out", outData, BLK_Y);
        check("tr_empty_last", {127'd0, outLast}, 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
